pipelined_carry_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output.
- The WIDTH-bit operation is split into STAGES equal chunks. Each chunk is a small combinational ripple adder, and the carry is registered between chunks.
- Sits in the datapath wherever wide adds must meet timing. One result per cycle at full throughput, with backpressure from downstream.

---
 rtl/adder_pkg.sv | 17 +
 rtl/rca_chunk.sv | 36 +++
 rtl/pipelined_carry_adder.sv | 165 ++++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry adder.
//   mode_e       : operation select (ADD / SUB)
//   signed_ovf() : two's-complement overflow from the carries around the MSB
package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Signed overflow happens exactly when the carry into the MSB differs
  // from the carry out of it.
  function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry chunk: a chain of W full adders.
// Ports:
//   a, b      : W-bit operands
//   ci        : carry into bit 0
//   s         : W-bit sum
//   co        : carry out of bit W-1
//   c_msb_in  : carry into bit W-1 (used for signed overflow)
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  // NOTE: every variable written here gets a value before any branch or
  // loop touches it, so the block can never infer a latch.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// The WIDTH-bit add is cut into STAGES chunks of CHUNK bits; each stage adds
// one chunk and registers the carry for the next.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready has no path from in_valid)
//   a, b, cin, sub       : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready: result handshake, result held while stalled
//   sum, cout, ovf       : registered result, carry out, signed overflow
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = WIDTH / STAGES_SAFE;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES_SAFE) != 0) begin : g_param_check
    $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  // Entry: B is inverted once here so the mode never has to travel down the pipe.
  mode_e            mode;
  logic [WIDTH-1:0] b_inv;
  logic             carry_in;

  assign mode     = mode_e'(sub);
  assign b_inv    = b ^ {WIDTH{mode == SUB}};
  assign carry_in = (mode == SUB) ? 1'b1 : cin;

  // A stage advances if it or any stage after it is empty, or the sink is
  // ready. Written as a suffix-AND so there is no combinational chain through
  // a vector referencing itself.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;

  always_comb begin
    logic all_full;
    adv      = '0;
    all_full = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      adv[k]   = !all_full || out_ready;
    end
  end

  assign in_ready = adv[0];

  // Each stage keeps a WIDTH-bit accumulator that rotates right by CHUNK:
  // the chunk to add is always in the low bits, and its sum is put back on
  // top. After STAGES rotations the accumulator holds the sum in order.
  // Remaining B bits are kept right-aligned and shrink by CHUNK per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int BW = WIDTH - k * CHUNK;

    logic [WIDTH-1:0] acc_in;
    logic [BW-1:0]    b_in;
    logic             c_in;
    logic             src_valid;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic             v_q;

    if (k == 0) begin : g_src
      assign acc_in    = a;
      assign b_in      = b_inv;
      assign c_in      = carry_in;
      assign src_valid = in_valid && adv[0];
    end else begin : g_src
      assign acc_in    = g_stage[k-1].g_reg.q.acc;
      assign b_in      = g_stage[k-1].g_reg.q.rb;
      assign c_in      = g_stage[k-1].g_reg.q.carry;
      assign src_valid = valid_q[k-1];
    end

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a        (acc_in[CHUNK-1:0]),
      .b        (b_in[CHUNK-1:0]),
      .ci       (c_in),
      .s        (s),
      .co       (co),
      .c_msb_in (c_msb)
    );

    // NOTE: sequential state is written with non-blocking assignments so
    // every stage samples its predecessor's value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (adv[k]) begin
        v_q <= src_valid;
      end
    end

    assign valid_q[k] = v_q;

    if (k < STAGES - 1) begin : g_reg
      typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] acc;
        logic [BW-CHUNK-1:0] rb;
      } stage_t;

      stage_t q;

      // NOTE: the data registers are reset too, so a flushed pipe holds
      // known zeros rather than stale operands.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (adv[k]) begin
          q.carry <= co;
          q.acc   <= {s, acc_in[WIDTH-1:CHUNK]};
          q.rb    <= b_in[BW-1:CHUNK];
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] sum_d;
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;

      if (STAGES == 1) begin : g_sum
        assign sum_d = s;
      end else begin : g_sum
        assign sum_d = {s, acc_in[WIDTH-1:CHUNK]};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv[k]) begin
          sum_q  <= sum_d;
          cout_q <= co;
          ovf_q  <= signed_ovf(c_msb, co);
        end
      end

      assign out_valid = v_q;
      assign sum       = sum_q;
      assign cout      = cout_q;
      assign ovf       = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed self-checking bench for pipelined_carry_adder (WIDTH=16, STAGES=4).
module tb_pipelined_carry_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an empty pipe with out_ready=1, then check the
  // latency (edges after the accepting edge) and the result.
  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tcin, input logic tsub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, S - 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
    tick();
    check({tag, "_single"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int rcv;
    logic stalled;
    logic [W-1:0] held;

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    tick();

    // Carry out of chunk 1 into chunk 2.
    run_one("add_latency", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    // Carry ripples through every chunk.
    run_one("full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    // Positive + positive overflows into negative.
    run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // Borrow; cin must be ignored in subtract mode.
    run_one("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: 8 beats, sink stalled for 6 cycles.
    idx = 0; rcv = 0; stalled = 1'b0; held = '0; sub = 1'b0; cin = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid  = (idx < 8);
      a = W'(idx);
      b = W'(idx);
      #1;
      if (cyc == 4) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted", idx, 4);
      end
      if (cyc == 6) check("bp_pass_through", in_ready, 1);
      if (stalled) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_sum", sum, held);
      end
      if (out_valid && out_ready) begin
        check("bp_order_sum", sum, W'(2 * rcv));
        rcv++;
      end
      stalled = out_valid && !out_ready;
      held    = sum;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_received", rcv, 8);
    tick();
    tick();
    check("bp_no_dup", out_valid, 0);

    // Bubble collapse: beats separated by idle cycles while stalled.
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    tick();
    tick();
    check("bub_valid_stalled", out_valid, 1);
    check("bub_sum_stalled", sum, 16'h2345);
    check("bub_in_ready", in_ready, 1);
    out_ready = 1'b1;
    #1;
    check("bub_first_valid", out_valid, 1);
    check("bub_first_sum", sum, 16'h2345);
    tick();
    check("bub_second_valid", out_valid, 1);
    check("bub_second_sum", sum, 16'hFFFF);
    tick();
    check("bub_drained", out_valid, 0);

    // Reset with 3 beats in flight.
    out_ready = 1'b0;
    a = 16'hFFFF; b = 16'h0002; in_valid = 1'b1; tick();
    a = 16'h0010; b = 16'h0020; tick();
    a = 16'h0030; b = 16'h0040; tick();
    in_valid = 1'b0; tick();
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_sum", sum, 16'h0001);
    check("mid_pre_cout", cout, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("mid_release_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_output", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
